// File: rtl/ds_fifo_vc.sv
// Multi-channel FWFT stream FIFO: NCH virtual-channel queues in one shared memory.
// Optional per-channel flush port enabled by DS_FIFO_VC_FLUSH_EN.
module ds_fifo_vc #(
   parameter type DTYPE = logic [7:0],
   parameter int NCH = 4,
   parameter int DEPTH = 8,
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int LW = $clog2(DEPTH + 1),
   localparam int DW = $bits(DTYPE)
) (
   input  logic              i_clk,
   input  logic              i_rst,
`ifdef DS_FIFO_VC_FLUSH_EN
   input  logic [NCH-1:0]    i_flush,
`endif
   input  logic              i_wr_vld,
   input  logic [CHW-1:0]    i_wr_ch,
   input  logic [DW-1:0]     i_wr_data,
   output logic              o_wr_rdy,
   input  logic [CHW-1:0]    i_rd_ch,
   output logic              o_rd_vld,
   output logic [DW-1:0]     o_rd_data,
   input  logic              i_rd_rdy,
   input  logic [LW-1:0]     i_thr,
   output logic [NCH*LW-1:0] o_lvl,
   output logic [NCH-1:0]    o_full,
   output logic [NCH-1:0]    o_empty,
   output logic [NCH-1:0]    o_lvl_gte
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AW = (NCH * DEPTH > 1) ? $clog2(NCH * DEPTH) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DEPTH - 1);
   localparam logic [LW-1:0] CFULL = LW'(DEPTH);

   logic [DW-1:0]  r_mem [NCH*DEPTH];
   logic [PW-1:0]  r_wptr [NCH];
   logic [PW-1:0]  r_rptr [NCH];
   logic [LW-1:0]  r_cnt [NCH];
   logic [LW-1:0]  w_cnt_nxt [NCH];
   logic [NCH-1:0] r_full;
   logic [NCH-1:0] r_empty;
   logic [NCH-1:0] w_flush;
   logic [NCH-1:0] w_we;
   logic [NCH-1:0] w_re;
   logic           w_wr_in;
   logic           w_rd_in;
   logic           w_wr_xfer;
   logic           w_rd_xfer;
   logic [AW-1:0]  w_wr_addr;
   logic [AW-1:0]  w_rd_addr;

`ifdef DS_FIFO_VC_FLUSH_EN
   assign w_flush = i_flush;
`else
   assign w_flush = '0;
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PMAX) ? '0 : p + PW'(1);
   endfunction

   assign w_wr_in = 32'(i_wr_ch) < NCH;
   assign w_rd_in = 32'(i_rd_ch) < NCH;

   // Out-of-range IDs are masked before any per-channel state is consulted
   assign o_wr_rdy = w_wr_in & ~r_full[i_wr_ch] & ~w_flush[i_wr_ch];
   assign o_rd_vld = w_rd_in & ~r_empty[i_rd_ch] & ~w_flush[i_rd_ch];

   assign w_wr_xfer = i_wr_vld & o_wr_rdy;
   assign w_rd_xfer = o_rd_vld & i_rd_rdy;

   assign w_wr_addr = AW'(32'(i_wr_ch) * DEPTH) + AW'(r_wptr[i_wr_ch]);
   assign w_rd_addr = AW'(32'(i_rd_ch) * DEPTH) + AW'(r_rptr[i_rd_ch]);

   assign o_rd_data = w_rd_in ? r_mem[w_rd_addr] : '0;

   always_comb begin
      w_we = '0;
      w_re = '0;
      for (int c = 0; c < NCH; c++) begin
         w_we[c] = w_wr_xfer & (i_wr_ch == CHW'(c));
         w_re[c] = w_rd_xfer & (i_rd_ch == CHW'(c));
         w_cnt_nxt[c] = r_cnt[c] + LW'(w_we[c]) - LW'(w_re[c]);
      end
   end

   always_comb begin
      o_lvl = '0;
      o_lvl_gte = '0;
      for (int c = 0; c < NCH; c++) begin
         o_lvl[c*LW +: LW] = r_cnt[c];
         o_lvl_gte[c] = r_cnt[c] >= i_thr;
      end
   end

   assign o_full = r_full;
   assign o_empty = r_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int c = 0; c < NCH; c++) begin
            r_wptr[c] <= '0;
            r_rptr[c] <= '0;
            r_cnt[c] <= '0;
         end
         r_full <= '0;
         r_empty <= '1;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (w_flush[c]) begin
               r_wptr[c] <= '0;
               r_rptr[c] <= '0;
               r_cnt[c] <= '0;
               r_full[c] <= 1'b0;
               r_empty[c] <= 1'b1;
            end else begin
               if (w_we[c]) r_wptr[c] <= ptr_inc(r_wptr[c]);
               if (w_re[c]) r_rptr[c] <= ptr_inc(r_rptr[c]);
               r_cnt[c] <= w_cnt_nxt[c];
               r_full[c] <= (w_cnt_nxt[c] == CFULL);
               r_empty[c] <= (w_cnt_nxt[c] == '0);
            end
         end
      end
   end

   // Storage is deliberately not reset; only the queue bookkeeping is
   always_ff @(posedge i_clk) begin
      if (w_wr_xfer) r_mem[w_wr_addr] <= i_wr_data;
   end

endmodule

// File: tb/tb_ds_fifo_vc.sv
// Bench for ds_fifo_vc: directed plan plus random traffic against a queue model.
// A second instance (NCH=3, DEPTH=1) covers out-of-range IDs and single-entry channels.
module tb_ds_fifo_vc;

   localparam int NCH = 4;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_vld = 1'b0;
   logic [1:0]  wr_ch = '0;
   logic [7:0]  wr_data = '0;
   logic        wr_rdy;
   logic [1:0]  rd_ch = '0;
   logic        rd_vld;
   logic [7:0]  rd_data;
   logic        rd_rdy = 1'b0;
   logic [3:0]  thr = '0;
   logic [15:0] lvl;
   logic [3:0]  full;
   logic [3:0]  empty;
   logic [3:0]  gte;
   logic [3:0]  fl = '0;

   logic        d3_wr_vld = 1'b0;
   logic [1:0]  d3_wr_ch = '0;
   logic [7:0]  d3_wr_data = '0;
   logic        d3_wr_rdy;
   logic [1:0]  d3_rd_ch = '0;
   logic        d3_rd_vld;
   logic [7:0]  d3_rd_data;
   logic        d3_rd_rdy = 1'b0;
   logic [0:0]  d3_thr = '0;
   logic [2:0]  d3_lvl;
   logic [2:0]  d3_full;
   logic [2:0]  d3_empty;
   logic [2:0]  d3_gte;
   logic [2:0]  d3_fl = '0;

   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] mq [NCH][$];

   always #5 clk = ~clk;

   ds_fifo_vc #(.DTYPE(logic [7:0]), .NCH(NCH), .DEPTH(DEPTH)) u_dut (
      .i_clk(clk),
      .i_rst(rst),
`ifdef DS_FIFO_VC_FLUSH_EN
      .i_flush(fl),
`endif
      .i_wr_vld(wr_vld),
      .i_wr_ch(wr_ch),
      .i_wr_data(wr_data),
      .o_wr_rdy(wr_rdy),
      .i_rd_ch(rd_ch),
      .o_rd_vld(rd_vld),
      .o_rd_data(rd_data),
      .i_rd_rdy(rd_rdy),
      .i_thr(thr),
      .o_lvl(lvl),
      .o_full(full),
      .o_empty(empty),
      .o_lvl_gte(gte)
   );

   ds_fifo_vc #(.DTYPE(logic [7:0]), .NCH(3), .DEPTH(1)) u_dut3 (
      .i_clk(clk),
      .i_rst(rst),
`ifdef DS_FIFO_VC_FLUSH_EN
      .i_flush(d3_fl),
`endif
      .i_wr_vld(d3_wr_vld),
      .i_wr_ch(d3_wr_ch),
      .i_wr_data(d3_wr_data),
      .o_wr_rdy(d3_wr_rdy),
      .i_rd_ch(d3_rd_ch),
      .o_rd_vld(d3_rd_vld),
      .o_rd_data(d3_rd_data),
      .i_rd_rdy(d3_rd_rdy),
      .i_thr(d3_thr),
      .o_lvl(d3_lvl),
      .o_full(d3_full),
      .o_empty(d3_empty),
      .o_lvl_gte(d3_gte)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_status();
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("lvl[%0d]", c), 32'(lvl[c*4 +: 4]), mq[c].size());
         chk($sformatf("full[%0d]", c), 32'(full[c]),
             32'(mq[c].size() == DEPTH));
         chk($sformatf("empty[%0d]", c), 32'(empty[c]),
             32'(mq[c].size() == 0));
         chk($sformatf("gte[%0d]", c), 32'(gte[c]),
             32'(mq[c].size() >= int'(thr)));
      end
   endtask

   task automatic step(input logic wv, input int wc, input logic [7:0] wd,
                       input int rc, input logic rr);
      logic erdy;
      logic evld;
      wr_vld = wv;
      wr_ch = wc[1:0];
      wr_data = wd;
      rd_ch = rc[1:0];
      rd_rdy = rr;
      #1;
      erdy = !fl[wc] && (mq[wc].size() < DEPTH);
      evld = !fl[rc] && (mq[rc].size() > 0);
      chk("wr_rdy", 32'(wr_rdy), 32'(erdy));
      chk("rd_vld", 32'(rd_vld), 32'(evld));
      if (evld) chk("rd_data", 32'(rd_data), 32'(mq[rc][0]));
      @(posedge clk);
      if (rr && evld) void'(mq[rc].pop_front());
      if (wv && erdy) mq[wc].push_back(wd);
      for (int c = 0; c < NCH; c++) if (fl[c]) mq[c].delete();
      #1;
      check_status();
      wr_vld = 1'b0;
      rd_rdy = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < NCH; c++) mq[c].delete();
      check_status();
   endtask

   initial begin
      // 1: reset state
      thr = 4'd3;
      do_reset();
      for (int c = 0; c < NCH; c++) step(1'b0, c, 8'h00, c, 1'b0);

      // 2: fill ch2, overflow attempt, drain in order
      for (int i = 0; i < 9; i++) step(1'b1, 2, 8'(8'h10 + i), 0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 0, 8'h00, 2, 1'b1);
      step(1'b0, 0, 8'h00, 2, 1'b1);

      // 3: interleaved channels
      step(1'b1, 0, 8'hA0, 3, 1'b0);
      step(1'b1, 1, 8'hB0, 3, 1'b0);
      step(1'b1, 0, 8'hA1, 3, 1'b0);
      step(1'b0, 0, 8'h00, 1, 1'b1);
      step(1'b0, 0, 8'h00, 0, 1'b1);
      step(1'b0, 0, 8'h00, 0, 1'b1);

      // 4: steady simultaneous write/read on ch3 across pointer wrap
      for (int i = 0; i < 4; i++) step(1'b1, 3, 8'(8'h30 + i), 0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 3, 8'(8'h40 + i), 3, 1'b1);

      // 5: no bypass on an empty channel
      step(1'b1, 1, 8'h5C, 1, 1'b1);
      step(1'b0, 0, 8'h00, 1, 1'b1);

`ifdef DS_FIFO_VC_FLUSH_EN
      // 6: flush ch1 while writing it, ch0 untouched
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1, 8'(8'h60 + i), 2, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 0, 8'(8'h70 + i), 2, 1'b0);
      fl = 4'b0010;
      step(1'b1, 1, 8'h99, 1, 1'b1);
      fl = 4'b0000;
      step(1'b0, 0, 8'h00, 0, 1'b0);
`endif

      // random traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) thr = 4'($urandom_range(0, DEPTH));
         step(1'($urandom_range(0, 3) != 0), $urandom_range(0, NCH - 1),
              8'($urandom), $urandom_range(0, NCH - 1),
              1'($urandom_range(0, 2) != 0));
      end

      // reset in the middle of traffic discards every queue
      do_reset();
      step(1'b0, 0, 8'h00, 0, 1'b1);

      // second instance: out-of-range IDs and DEPTH=1
      d3_thr = 1'b1;
      d3_wr_vld = 1'b1;
      d3_wr_ch = 2'd3;
      d3_wr_data = 8'hEE;
      d3_rd_ch = 2'd3;
      d3_rd_rdy = 1'b1;
      #1;
      chk("d3_rdy_oor", 32'(d3_wr_rdy), 32'd0);
      chk("d3_vld_oor", 32'(d3_rd_vld), 32'd0);
      chk("d3_data_oor", 32'(d3_rd_data), 32'd0);
      @(posedge clk);
      #1;
      chk("d3_lvl_oor", 32'(d3_lvl), 32'd0);
      chk("d3_empty_oor", 32'(d3_empty), 32'b111);
      d3_rd_rdy = 1'b0;
      d3_wr_ch = 2'd1;
      d3_wr_data = 8'h5A;
      #1;
      chk("d3_rdy_ch1", 32'(d3_wr_rdy), 32'd1);
      @(posedge clk);
      #1;
      d3_wr_vld = 1'b0;
      chk("d3_full_1", 32'(d3_full), 32'b010);
      chk("d3_empty_1", 32'(d3_empty), 32'b101);
      chk("d3_lvl_1", 32'(d3_lvl), 32'b010);
      chk("d3_gte_1", 32'(d3_gte), 32'b010);
      chk("d3_rdy_full", 32'(d3_wr_rdy), 32'd0);
      d3_rd_ch = 2'd1;
      d3_rd_rdy = 1'b1;
      #1;
      chk("d3_vld_1", 32'(d3_rd_vld), 32'd1);
      chk("d3_data_1", 32'(d3_rd_data), 32'h5A);
      @(posedge clk);
      #1;
      d3_rd_rdy = 1'b0;
      chk("d3_empty_2", 32'(d3_empty), 32'b111);
      chk("d3_full_2", 32'(d3_full), 32'b000);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ds_fifo_vc.md
Name: ds_fifo_vc

Overview:
Multi-channel stream FIFO with NCH independent virtual-channel queues of DEPTH entries each, statically partitioned in one shared memory.
- Single write port steered by channel ID; single read port with per-cycle channel select.
- Successor to the single-queue FIFO; used for per-class/per-port buffering in front of arbiters and schedulers in lib_ds.
- Adds per-channel counts, full/empty flags and a threshold flag.

Parameters:
DTYPE, logic [7:0], payload type
NCH, 4, number of channels (>=1)
DEPTH, 8, entries per channel (>=1, need not be a power of two)
CHW (derived), max(1, clog2(NCH)), channel ID width
LW (derived), clog2(DEPTH+1), per-channel level width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_wr_vld  in  1  write valid
i_wr_ch  in  CHW  write channel ID
i_wr_data  in  $bits(DTYPE)  write payload
o_wr_rdy  out  1  write ready for channel i_wr_ch
i_rd_ch  in  CHW  read channel select
o_rd_vld  out  1  selected channel non-empty
o_rd_data  out  $bits(DTYPE)  head entry of selected channel
i_rd_rdy  in  1  read ready
i_thr  in  LW  level threshold, common to all channels
o_lvl  out  NCH*LW  per-channel word count; channel c at [c*LW +: LW]
o_full  out  NCH  per-channel full
o_empty  out  NCH  per-channel empty
o_lvl_gte  out  NCH  per-channel count >= i_thr

Behaviour:
Reset and transfers:
- Reset i_rst, synchronous, active-high; clock i_clk.
- On reset, all pointers and counts go to 0, o_empty = all 1s, o_full = 0, o_lvl = 0, and o_lvl_gte[c] = (i_thr == 0).
- Write transfer: wr_xfer = i_wr_vld & o_wr_rdy. Read transfer: rd_xfer = o_rd_vld & i_rd_rdy.

Handshake (combinational from registered state):
- o_wr_rdy = (i_wr_ch < NCH) & ~o_full[i_wr_ch].
- o_rd_vld = (i_rd_ch < NCH) & ~o_empty[i_rd_ch].
- o_rd_vld and o_rd_data may change whenever i_rd_ch changes; no handshake hold is required across a channel switch.

Memory and latency:
- NCH*DEPTH entries. Channel c owns addresses c*DEPTH .. c*DEPTH+DEPTH-1.
- Per-channel write and read pointers are 0..DEPTH-1 and wrap DEPTH-1 -> 0 on each transfer.
- Operation is first-word fall-through: o_rd_data = mem[i_rd_ch*DEPTH + rd_ptr[i_rd_ch]], combinational. It is 0 when i_rd_ch >= NCH.
- Write-to-read latency is 1 cycle: data written at edge N is visible with o_rd_vld = 1 in cycle N+1.

Count update per channel c:
- Write only to c: count +1.
- Read only from c: count -1.
- Write and read both on c: count unchanged, both pointers advance.
- Write and read on different channels: each channel updates independently in the same cycle.
- o_full[c] and o_empty[c] are registered from the next count.
- o_lvl_gte[c] = count[c] >= i_thr, combinational from the registered count.

Boundaries:
- Full channel: o_wr_rdy = 0 even if the same channel is read in that cycle. There is no full pass-through.
- Empty channel: o_rd_vld = 0 even if the same channel is written in that cycle. There is no bypass.
- Out-of-range ID: i_wr_ch >= NCH drops the write (rdy = 0); i_rd_ch >= NCH gives vld = 0.
- DEPTH = 1: a channel alternates between full and empty.
- Reset mid-traffic: all queues are discarded; memory contents are not cleared.

Optional Feature:
Macro: DS_FIFO_VC_FLUSH_EN
- Enabled: adds port i_flush, input, width NCH, per-channel synchronous flush.
- For each c with i_flush[c] = 1, in that cycle o_wr_rdy and o_rd_vld are forced 0 when the selected channel is c.
- At the next edge, c's pointers and count reset to 0, o_empty[c] = 1 and o_full[c] = 0.
- Flush overrides any write/read on c in the same cycle. Other channels are unaffected.
- Disabled: the port is absent and no flush logic is built.

Test Plan:
1. Reset, then NCH=4, DEPTH=8, i_thr=3 -> o_empty=4'b1111, o_full=0, o_lvl all 0, o_lvl_gte=0; rdy=1 for ch 0..3.
2. Write 8 words 0x10..0x17 to ch2, then a 9th write -> o_full[2]=1, o_wr_rdy=0 for ch2, o_lvl ch2=8, o_lvl_gte[2]=1. Read ch2 -> 0x10..0x17 in order, then o_empty[2]=1.
3. Interleave writes ch0=0xA0, ch1=0xB0, ch0=0xA1, then read ch1 then ch0 x2 -> 0xB0, 0xA0, 0xA1; no cross-channel corruption.
4. With ch3 holding 4 words, write and read ch3 simultaneously for 20 cycles (pointer wrap) -> count stays 4 and data order is preserved.
5. i_wr_ch=3 with NCH=3, i_wr_vld=1 -> o_wr_rdy=0 and no count change. Write to empty ch1 while i_rd_ch=1 -> o_rd_vld=0 that cycle, 1 the next cycle.
6. (FLUSH_EN) Fill ch1 with 5 words and ch0 with 2, pulse i_flush=4'b0010 with a concurrent ch1 write -> next cycle ch1 count 0, o_empty[1]=1, write not accepted; ch0 count stays 2.
